// File: rtl/mcu_spi_select.sv
// MCU SPI source selector: glitch-filtered M0S Dock detect with a guarded, between-frame handover.
// Optional macro MCU_SPI_REVERT_EN adds idle-timeout fallback from the dock back to the on-board source.
module mcu_spi_select #(
  parameter int DETECT_CYCLES = 8,
  parameter int GUARD_CYCLES  = 4,
  parameter int REVERT_CYCLES = 32000000
) (
  input  logic clk32,
  input  logic reset_n,
  input  logic int_sclk,
  input  logic int_csn,
  input  logic int_mosi,
  input  logic ext_sclk,
  input  logic ext_csn,
  input  logic ext_mosi,
  output logic mcu_sclk,
  output logic mcu_csn,
  output logic mcu_mosi,
  output logic ext_active,
  output logic switch_busy
);

  localparam logic [7:0] DETECT_LIM = 8'(DETECT_CYCLES);
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  if (DETECT_CYCLES < 1 || DETECT_CYCLES > 255 || GUARD_CYCLES < 1 || GUARD_CYCLES > 255 ||
      REVERT_CYCLES < 1 || REVERT_CYCLES > 33554431) begin : g_bad_params
    $error("mcu_spi_select: parameter out of range");
  end

`ifdef MCU_SPI_REVERT_EN
  typedef enum logic [2:0] {ST_INT, ST_PEND_EXT, ST_GUARD, ST_EXT, ST_PEND_INT} state_t;
`else
  typedef enum logic [1:0] {ST_INT, ST_PEND_EXT, ST_GUARD, ST_EXT} state_t;
`endif

  state_t      state_reg;
  state_t      state_next;
  logic [1:0]  csn_raw;
  logic [1:0]  csn_sync;
  logic        s_int_csn;
  logic        s_ext_csn;
  logic [7:0]  detect_cnt_reg;
  logic        detect;
  logic [7:0]  guard_cnt_reg;
  logic        target_ext_reg;
  logic        guard_entry;
  logic        revert_done;

  // Chip selects idle high, so the synchronizers reset to 1.
  assign csn_raw = {ext_csn, int_csn};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_sync
    logic [1:0] pipe_reg;
    always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) pipe_reg <= 2'b11;
      else          pipe_reg <= {pipe_reg[0], csn_raw[gi]};
    end
    assign csn_sync[gi] = pipe_reg[1];
  end

  assign s_int_csn = csn_sync[0];
  assign s_ext_csn = csn_sync[1];
  assign detect    = (detect_cnt_reg == DETECT_LIM);

`ifdef MCU_SPI_REVERT_EN
  localparam logic [24:0] REVERT_LIM = 25'(REVERT_CYCLES);
  logic [24:0] idle_cnt_reg;
  logic        idle_hit;

  assign idle_hit    = (idle_cnt_reg == REVERT_LIM);
  assign revert_done = (state_reg == ST_GUARD) && (state_next == ST_INT);

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n)                               idle_cnt_reg <= '0;
    else if (state_reg != ST_EXT || !s_ext_csn) idle_cnt_reg <= '0;
    else if (!idle_hit)                         idle_cnt_reg <= idle_cnt_reg + 25'd1;
  end
`else
  assign revert_done = 1'b0;
`endif

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n)                      detect_cnt_reg <= '0;
    else if (s_ext_csn || revert_done) detect_cnt_reg <= '0;
    else if (!detect)                  detect_cnt_reg <= detect_cnt_reg + 8'd1;
  end

  // Target is latched on GUARD entry so the exit direction cannot change mid-guard.
  assign guard_entry = (state_next == ST_GUARD) && (state_reg != ST_GUARD);

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      guard_cnt_reg  <= '0;
      target_ext_reg <= 1'b0;
    end else if (guard_entry) begin
      guard_cnt_reg  <= GUARD_LOAD;
      target_ext_reg <= (state_reg == ST_INT) || (state_reg == ST_PEND_EXT);
    end else if (state_reg == ST_GUARD && guard_cnt_reg != 8'd0) begin
      guard_cnt_reg  <= guard_cnt_reg - 8'd1;
    end
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_INT;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INT:      if (detect) state_next = s_int_csn ? ST_GUARD : ST_PEND_EXT;
      ST_PEND_EXT: if (s_int_csn) state_next = ST_GUARD;
      ST_GUARD:    if (guard_cnt_reg == 8'd0) state_next = target_ext_reg ? ST_EXT : ST_INT;
`ifdef MCU_SPI_REVERT_EN
      ST_EXT:      if (idle_hit) state_next = ST_PEND_INT;
      ST_PEND_INT: if (s_ext_csn) state_next = ST_GUARD;
`endif
      default:     state_next = state_reg;
    endcase
  end

  // Muxes stay combinational so the SPI path itself gains no latency.
  always_comb begin
    mcu_sclk    = int_sclk;
    mcu_csn     = int_csn;
    mcu_mosi    = int_mosi;
    ext_active  = 1'b0;
    switch_busy = 1'b0;
    case (state_reg)
      ST_PEND_EXT: switch_busy = 1'b1;
      ST_GUARD: begin
        mcu_sclk    = 1'b0;
        mcu_csn     = 1'b1;
        mcu_mosi    = 1'b0;
        switch_busy = 1'b1;
      end
      ST_EXT: begin
        mcu_sclk   = ext_sclk;
        mcu_csn    = ext_csn;
        mcu_mosi   = ext_mosi;
        ext_active = 1'b1;
      end
`ifdef MCU_SPI_REVERT_EN
      ST_PEND_INT: begin
        mcu_sclk    = ext_sclk;
        mcu_csn     = ext_csn;
        mcu_mosi    = ext_mosi;
        switch_busy = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
